// File: rtl/uart_tx_arbiter_if.sv
// Byte-request and UART-transmit signal bundle for uart_tx_arbiter.
// The slave modport is the arbiter. The master modport is the requesters plus the transmitter side.
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       owner;
    logic       locked;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        input  req0_ready, req1_ready, tx_start, tx_data, owner, locked
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        output req0_ready, req1_ready, tx_start, tx_data, owner, locked
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Line-locked two-requester arbiter for a single UART transmitter.
// A grant is held until LOCK_CHAR has been sent, or until the owner has been idle for TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter logic [7:0]  LOCK_CHAR = 8'h0A,
    parameter int unsigned TIMEOUT   = 2500000
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, GRANT, START, WAIT_BUSY, WAIT_DONE} state_t;

    localparam logic [23:0] TIMEOUT_C = 24'(TIMEOUT);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [23:0] idle_cnt_q, idle_cnt_d;
    logic [23:0] cnt_inc;
    logic        own_valid;
    logic [7:0]  own_data;

    assign own_valid = owner_q ? bus.req1_valid : bus.req0_valid;
    assign own_data  = owner_q ? bus.req1_data  : bus.req0_data;
    assign cnt_inc   = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 24'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            tx_data_q    <= 8'h00;
            idle_cnt_q   <= 24'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            tx_data_q    <= tx_data_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        tx_data_d    = tx_data_q;
        idle_cnt_d   = idle_cnt_q;
        case (state_q)
            IDLE: begin
                idle_cnt_d = 24'd0;
                if (bus.req0_valid || bus.req1_valid) begin
                    // On a tie, the requester that did not hold the last grant wins.
                    owner_d = (bus.req0_valid && bus.req1_valid) ? ~last_owner_q : bus.req1_valid;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (own_valid) begin
                    tx_data_d  = own_data;
                    idle_cnt_d = 24'd0;
                    state_d    = START;
                end else begin
                    idle_cnt_d = cnt_inc;
                    if (TIMEOUT_C != 24'd0 && cnt_inc >= TIMEOUT_C) begin
                        last_owner_d = owner_q;
                        idle_cnt_d   = 24'd0;
                        state_d      = IDLE;
                    end
                end
            end
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (bus.tx_busy) state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (tx_data_q == LOCK_CHAR) begin
                        last_owner_d = owner_q;
                        state_d      = IDLE;
                    end else begin
                        idle_cnt_d = 24'd0;
                        state_d    = GRANT;
                    end
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    assign bus.req0_ready = (state_q == GRANT) && !owner_q;
    assign bus.req1_ready = (state_q == GRANT) &&  owner_q;
    assign bus.tx_start   = (state_q == START);
    assign bus.tx_data    = tx_data_q;
    assign bus.owner      = owner_q;
    assign bus.locked     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter.
// Queue-driven requesters and a busy-model transmitter run against a line-level reference model.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.LOCK_CHAR(8'h0A), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] obs[$];
    logic [7:0] exp_q[$];
    logic [7:0] busy_data = 8'h00;
    int  rem = 0;
    int  busy_len = 10;
    bit  busy_rand = 1'b0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Requesters present the head of their queue and pop it on a ready/valid handshake.
    always @(posedge clk) begin
        automatic bit hs0 = bus.req0_valid && bus.req0_ready;
        automatic bit hs1 = bus.req1_valid && bus.req1_ready;
        #1;
        if (hs0 && q0.size() > 0) void'(q0.pop_front());
        if (hs1 && q1.size() > 0) void'(q1.pop_front());
        bus.req0_valid = (q0.size() > 0);
        bus.req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
        bus.req1_valid = (q1.size() > 0);
        bus.req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
    end

    // Transmitter: busy rises the cycle after tx_start and stays high for a programmable time.
    always @(posedge clk) begin
        if (bus.tx_start) begin
            obs.push_back(bus.tx_data);
            busy_data = bus.tx_data;
            rem = busy_rand ? int'($urandom_range(1, 8)) : busy_len;
            #1 bus.tx_busy = 1'b1;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) #1 bus.tx_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("one_ready", 32'(bus.req0_ready & bus.req1_ready), 0);
            chk("ready_needs_lock", 32'((bus.req0_ready | bus.req1_ready) & ~bus.locked), 0);
            chk("start_while_busy", 32'(bus.tx_start & bus.tx_busy), 0);
            if (bus.tx_busy) chk("tx_data_stable", 32'(bus.tx_data), 32'(busy_data));
        end
    end

    task automatic wait_obs(input int n, input int budget, input string tag);
        int c = 0;
        while (obs.size() < n && c < budget) begin @(negedge clk); c++; end
        chk(tag, 32'(obs.size()), 32'(n));
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (bus.locked && c < 2000) begin @(negedge clk); c++; end
        chk(tag, 32'(bus.locked), 0);
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, 32'(obs.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) chk(tag, 32'(obs[i]), 32'(exp_q[i]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q0.delete(); q1.delete();
        rem = 0; bus.tx_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        obs.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_start"}, 32'(bus.tx_start), 0);
        chk({tag, "_tx_data"},  32'(bus.tx_data), 0);
        chk({tag, "_owner"},    32'(bus.owner), 0);
        chk({tag, "_locked"},   32'(bus.locked), 0);
        chk({tag, "_ready0"},   32'(bus.req0_ready), 0);
        chk({tag, "_ready1"},   32'(bus.req1_ready), 0);
    endtask

    initial begin
        int n;
        int cnt_a;
        int cnt_b;
        int cnt_c;
        bus.req0_valid = 1'b0; bus.req0_data = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00;
        bus.tx_busy = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // One line from req0.
        rst = 1'b0;
        q0 = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
        exp_q = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
        wait_obs(4, 400, "line0_count");
        wait_idle("line0_release");
        cmp_stream("line0_byte");
        chk("line0_owner", 32'(bus.owner), 0);

        // Tie right after reset goes to req0, then req1; the next tie goes back to req0.
        do_reset();
        q0 = '{8'h11, 8'h22, 8'h0A};
        q1 = '{8'h33, 8'h0A};
        exp_q = '{8'h11, 8'h22, 8'h0A, 8'h33, 8'h0A};
        wait_obs(5, 500, "tie1_count");
        wait_idle("tie1_release");
        cmp_stream("tie1_byte");
        chk("tie1_owner", 32'(bus.owner), 1);
        obs.delete();
        q0 = '{8'h44, 8'h0A};
        q1 = '{8'h55, 8'h0A};
        exp_q = '{8'h44, 8'h0A, 8'h55, 8'h0A};
        wait_obs(4, 500, "tie2_count");
        wait_idle("tie2_release");
        cmp_stream("tie2_byte");

        // A latecomer is held off until the current line ends.
        obs.delete();
        q0 = '{8'h61, 8'h62, 8'h0A};
        wait_obs(1, 200, "late_first");
        q1 = '{8'h71, 8'h0A};
        cnt_a = 0; n = 0;
        while (obs.size() < 3 && n < 500) begin
            @(negedge clk); n++;
            if (bus.req1_ready) cnt_a++;
        end
        chk("late_ready1_held", 32'(cnt_a), 0);
        wait_obs(5, 500, "late_count");
        wait_idle("late_release");
        exp_q = '{8'h61, 8'h62, 8'h0A, 8'h71, 8'h0A};
        cmp_stream("late_byte");

        // Owner goes quiet mid-line: 16 idle grant cycles, one release cycle, then req1.
        obs.delete();
        q0 = '{8'h41};
        wait_obs(1, 200, "to_first");
        q1 = '{8'h52, 8'h0A};
        n = 0;
        while (!bus.req0_ready && n < 200) begin @(negedge clk); n++; end
        cnt_a = 0;
        while (bus.req0_ready && cnt_a < 100) begin @(negedge clk); cnt_a++; end
        chk("to_grant_cycles", 32'(cnt_a), 16);
        chk("to_release_cycle", 32'(bus.locked), 0);
        @(negedge clk);
        chk("to_regrant_ready1", 32'(bus.req1_ready), 1);
        chk("to_regrant_owner", 32'(bus.owner), 1);
        wait_obs(3, 500, "to_count");
        wait_idle("to_release");
        exp_q = '{8'h41, 8'h52, 8'h0A};
        cmp_stream("to_byte");

        // Long busy: nothing moves until the frame completes.
        obs.delete();
        busy_len = 1000;
        q0 = '{8'hA5, 8'h0A};
        wait_obs(1, 200, "busy_first");
        busy_len = 10;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        repeat (990) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) cnt_a++;
            if (bus.tx_start) cnt_b++;
            if (!bus.locked) cnt_c++;
        end
        chk("busy_no_ready", 32'(cnt_a), 0);
        chk("busy_no_start", 32'(cnt_b), 0);
        chk("busy_stays_locked", 32'(cnt_c), 0);
        wait_obs(2, 500, "busy_count");
        wait_idle("busy_release");
        exp_q = '{8'hA5, 8'h0A};
        cmp_stream("busy_byte");

        // Asynchronous reset while req1 is in WAIT_DONE.
        obs.delete();
        q1 = '{8'hC3, 8'h0A};
        wait_obs(1, 200, "rst_first");
        repeat (4) @(negedge clk);
        chk("rst_pre_owner", 32'(bus.owner), 1);
        #2;
        rst = 1'b1;
        q0.delete(); q1.delete();
        rem = 0; bus.tx_busy = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        cnt_b = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx_start) cnt_b++;
        end
        chk("rst_no_start", 32'(cnt_b), 0);
        chk("rst_obs", 32'(obs.size()), 1);

        // Randomized lines from both sides, both queues loaded at once.
        for (int r = 0; r < 3; r++) begin
            logic [7:0] a0[$];
            logic [7:0] a1[$];
            logic [7:0] m0[$];
            logic [7:0] m1[$];
            logic [7:0] b;
            int turn;
            int pick;
            do_reset();
            busy_rand = 1'b1;
            for (int s = 0; s < 2; s++) begin
                int lines = $urandom_range(1, 4);
                for (int l = 0; l < lines; l++) begin
                    int len = $urandom_range(0, 4);
                    for (int k = 0; k < len; k++) begin
                        b = 8'($urandom_range(0, 255));
                        if (b == 8'h0A) b = 8'h0B;
                        if (s == 0) a0.push_back(b); else a1.push_back(b);
                    end
                    if (s == 0) a0.push_back(8'h0A); else a1.push_back(8'h0A);
                end
            end
            // Whole lines alternate, req0 first after reset; a drained side forfeits its turns.
            exp_q.delete();
            m0 = a0; m1 = a1; turn = 0;
            while (m0.size() > 0 || m1.size() > 0) begin
                if (m0.size() > 0 && m1.size() > 0) pick = turn;
                else pick = (m0.size() > 0) ? 0 : 1;
                do begin
                    b = (pick == 0) ? m0.pop_front() : m1.pop_front();
                    exp_q.push_back(b);
                end while (b != 8'h0A);
                turn = 1 - pick;
            end
            q0 = a0; q1 = a1;
            wait_obs(exp_q.size(), 40 * exp_q.size() + 100, "rand_count");
            wait_idle("rand_release");
            cmp_stream("rand_byte");
            busy_rand = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
